// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the multiplexed 7-segment scan driver.
//   GLYPH_TABLE : 16-entry hex glyph table, active-low form, bit order {g,f,e,d,c,b,a}
//   SEG_OFF     : all segments dark, active-low form
//   onehot_idx  : digit index (0..7) to one-hot, active-high form
package seg7_pkg;

  // Entry 15 is listed first so that GLYPH_TABLE[d] selects the glyph for hex digit d.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic [7:0] onehot_idx(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode -- combinational hex digit to 7-segment glyph lookup.
//   ACTIVE_LOW : 1 = lit segments driven low, 0 = lit segments driven high
// Ports:
//   digit in  4  hex digit to display
//   seg   out 7  glyph {g,f,e,d,c,b,a} in the selected polarity
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = ACTIVE_LOW ? GLYPH_TABLE[digit] : ~GLYPH_TABLE[digit];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- multiplexed N-digit 7-segment display driver.
// Holds a shadow copy of DIGITS hex digits plus decimal points and scans them
// onto one shared segment bus, one digit slot of SCAN_DIV cycles each. The
// anode stays dark for the first cycle of every slot so the segment bus has
// settled before the new digit is enabled. All outputs are registered.
// Optional build macro: LEADING_ZERO_SUPPRESS_EN -- blanks zero digits above
// the most significant nonzero digit (digit 0 always shown, dp still shown).
// Ports:
//   clk      in  1         system clock
//   reset    in  1         synchronous active-high reset
//   value    in  4*DIGITS  hex digits, digit 0 in value[3:0] (rightmost)
//   dp       in  DIGITS    decimal-point request per digit, active-high
//   load     in  1         capture value/dp into the shadow register
//   blank_en in  1         force all anodes inactive
//   seg      out 7         segment bus {g,f,e,d,c,b,a}
//   dp_out   out 1         decimal-point segment
//   an       out DIGITS    one-hot digit enables
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank_en,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     an
);

  localparam int P_W   = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [P_W-1:0]    P_LAST   = P_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_DARK = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic              DP_DARK  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_DARK  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] shadow_value_reg;
  logic [DIGITS-1:0]   shadow_dp_reg;
  logic [P_W-1:0]      p_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [6:0]          seg_reg;
  logic                dp_out_reg;
  logic [DIGITS-1:0]   an_reg;

  // Current digit, selected from the shadow register by the scan index.
  logic [3:0] digit_arr [DIGITS];
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       cur_supp;
  logic [6:0] cur_glyph;
  logic [DIGITS-1:0] an_onehot;
  logic [DIGITS-1:0] an_lit;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = shadow_value_reg[4*gi +: 4];
    end
  endgenerate

  assign cur_digit = digit_arr[idx_reg];
  assign cur_dp    = shadow_dp_reg[idx_reg];
  assign an_onehot = DIGITS'(onehot_idx(3'(idx_reg)));
  assign an_lit    = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;

  seg7_hex_decode #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_decode (
    .digit (cur_digit),
    .seg   (cur_glyph)
  );

`ifdef LEADING_ZERO_SUPPRESS_EN
  // A digit is suppressed while it and every digit above it are zero.
  // Digit 0 is excluded so an all-zero value still shows a single 0.
  logic [DIGITS-1:0] supp_mask;
  logic              zero_run;

  always_comb begin
    supp_mask = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run && (shadow_value_reg[4*i +: 4] == 4'd0);
      supp_mask[i] = zero_run;
    end
  end

  assign cur_supp = supp_mask[idx_reg];
`else
  assign cur_supp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      p_reg            <= '0;
      idx_reg          <= '0;
      seg_reg          <= SEG_DARK;
      dp_out_reg       <= DP_DARK;
      an_reg           <= AN_DARK;
    end else begin
      if (load) begin
        shadow_value_reg <= value;
        shadow_dp_reg    <= dp;
      end

      if (p_reg == P_LAST) begin
        p_reg   <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        p_reg <= p_reg + 1'b1;
      end

      seg_reg    <= cur_supp ? SEG_DARK : cur_glyph;
      dp_out_reg <= SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
      // Dead cycle at slot start; a suppressed digit only lights for its dp.
      if ((p_reg == '0) || blank_en || (cur_supp && !cur_dp)) begin
        an_reg <= AN_DARK;
      end else begin
        an_reg <= an_lit;
      end
    end
  end

  assign seg    = seg_reg;
  assign dp_out = dp_out_reg;
  assign an     = an_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver -- directed bench for seg7_scan_driver (DIGITS=4,
// SCAN_DIV=4, active-low segments and anodes). A cycle-count model derives
// the expected outputs from the scan position and the loaded data; literal
// checks pin selected cycles of the scan.
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_en;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;
  int edge_no;

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .dp       (dp),
    .load     (load),
    .blank_en (blank_en),
    .seg      (seg),
    .dp_out   (dp_out),
    .an       (an)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int          m_cnt;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  bit          model_valid = 0;

  function automatic int slot_idx(input int c);
    return (c / SCAN_DIV) % DIGITS;
  endfunction

  function automatic bit slot_start(input int c);
    return (c % SCAN_DIV) == 0;
  endfunction

  function automatic bit m_supp(input logic [15:0] v, input int i);
`ifdef LEADING_ZERO_SUPPRESS_EN
    int msd = 0;
    for (int k = 0; k < DIGITS; k++) if (v[4*k +: 4] != 4'd0) msd = k;
    return i > msd;
`else
    return (v === 16'hxxxx) && (i < 0);
`endif
  endfunction

  function automatic logic [6:0] m_seg(input int c, input logic [15:0] v);
    int i = slot_idx(c);
    if (m_supp(v, i)) return 7'b1111111;
    return glyph_tab[v[4*i +: 4]];
  endfunction

  function automatic logic [3:0] m_an(input int c, input logic [15:0] v, input logic [3:0] d, input logic b);
    int i = slot_idx(c);
    if (slot_start(c) || b) return 4'b1111;
    if (m_supp(v, i) && !d[i]) return 4'b1111;
    return ~(4'b0001 << i);
  endfunction

  function automatic logic m_dpo(input int c, input logic [3:0] d);
    return ~d[slot_idx(c)];
  endfunction

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (reset) begin
      m_cnt   <= 0;
      m_val   <= '0;
      m_dp    <= '0;
      exp_seg <= 7'b1111111;
      exp_dp  <= 1'b1;
      exp_an  <= 4'b1111;
    end else begin
      exp_seg <= m_seg(m_cnt, m_val);
      exp_dp  <= m_dpo(m_cnt, m_dp);
      exp_an  <= m_an(m_cnt, m_val, m_dp, blank_en);
      m_cnt   <= m_cnt + 1;
      if (load) begin
        m_val <= value;
        m_dp  <= dp;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("sb_seg", 32'(seg), 32'(exp_seg));
      check("sb_dp_out", 32'(dp_out), 32'(exp_dp));
      check("sb_an", 32'(an), 32'(exp_an));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic run_to(input int k);
    while (edge_no < k) step();
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s);
    check({name, "_an"}, 32'(an), 32'(a));
    check({name, "_seg"}, 32'(seg), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; blank_en = 1'b0;
    edge_no = 0;
    step(); step();
    lit("reset", 4'b1111, 7'b1111111);
    check("reset_dp_out", 32'(dp_out), 32'd1);

    // Release with a load on the first edge.
    reset = 1'b0; load = 1'b1; value = 16'h12AF; edge_no = -1;
    step();                         // E0: dead cycle
    check("release_an", 32'(an), 32'hF);
    load = 1'b0;
    run_to(1);  lit("d0_first", 4'b1110, 7'b0001110);
    run_to(3);  lit("d0_last",  4'b1110, 7'b0001110);
    run_to(4);  lit("d1_dead",  4'b1111, 7'b0001000);
    run_to(5);  lit("d1_on",    4'b1101, 7'b0001000);
    run_to(16); check("frame_dead_an", 32'(an), 32'hF);
    run_to(17); lit("frame_d0", 4'b1110, 7'b0001110);

    // Load on the terminal-count edge of digit 3.
    run_to(30);
    load = 1'b1; value = 16'h12A0;
    step();     lit("tc_d3",    4'b0111, 7'b1111001);
    load = 1'b0;
    step();     lit("tc_dead",  4'b1111, 7'b1000000);
    step();     lit("tc_d0",    4'b1110, 7'b1000000);

    // Blanking keeps the scan running.
    blank_en = 1'b1;
    step();     check("blank_first_an", 32'(an), 32'hF);
    run_to(35); lit("blank_mid", 4'b1111, 7'b1000000);
    run_to(43); check("blank_last_an", 32'(an), 32'hF);
    blank_en = 1'b0;
    step();     check("unblank_dead_an", 32'(an), 32'hF);
    step();     lit("unblank_d3", 4'b0111, 7'b1111001);

    // Decimal point on digit 1 only.
    load = 1'b1; dp = 4'b0010;
    step();
    load = 1'b0;
    run_to(49); check("dp_d0", 32'(dp_out), 32'd1);
    run_to(53); check("dp_d1", 32'(dp_out), 32'd0);
    check("dp_d1_an", 32'(an), 32'hD);

    // Leading zeros: 0040.
    load = 1'b1; dp = 4'b0000; value = 16'h0040;
    step();
    load = 1'b0;
    run_to(65); lit("lz40_d0", 4'b1110, 7'b1000000);
    run_to(69); lit("lz40_d1", 4'b1101, 7'b0011001);
`ifdef LEADING_ZERO_SUPPRESS_EN
    run_to(73); lit("lz40_d2", 4'b1111, 7'b1111111);
    run_to(77); lit("lz40_d3", 4'b1111, 7'b1111111);
`else
    run_to(73); lit("lz40_d2", 4'b1011, 7'b1000000);
    run_to(77); lit("lz40_d3", 4'b0111, 7'b1000000);
`endif

    // All zero.
    load = 1'b1; value = 16'h0000;
    step();
    load = 1'b0;
    run_to(81); lit("lz0_d0", 4'b1110, 7'b1000000);
`ifdef LEADING_ZERO_SUPPRESS_EN
    run_to(85); lit("lz0_d1", 4'b1111, 7'b1111111);
`else
    run_to(85); lit("lz0_d1", 4'b1101, 7'b1000000);
`endif

    // Zero digit with its dp set: anode lit for the dp.
    load = 1'b1; dp = 4'b0100;
    step();
    load = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    run_to(89); lit("lzdp_d2", 4'b1011, 7'b1111111);
`else
    run_to(89); lit("lzdp_d2", 4'b1011, 7'b1000000);
`endif
    check("lzdp_dp_out", 32'(dp_out), 32'd0);

    // Reset mid-scan, with a load request that must be ignored.
    run_to(90);
    reset = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    lit("midrst", 4'b1111, 7'b1111111);
    check("midrst_dp_out", 32'(dp_out), 32'd1);
    reset = 1'b0; load = 1'b0;

    // Mixed traffic checked by the model.
    for (int i = 0; i < 60; i++) begin
      load     = (i % 7) == 3;
      value    = 16'($urandom);
      dp       = 4'($urandom);
      blank_en = (i % 13) > 10;
      step();
    end
    load = 1'b0; blank_en = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
